// File: rtl/lcd_scanout.sv
// lcd_scanout: raster timing generator and framebuffer scan-out for a 480x272 RGB panel.
// Reads 8-bit RGB332 words from a synchronous-read RAM, replicates each word over an
// 8x8 pixel block and drives RGB565 with DE/HSYNC/VSYNC through a fixed 3-stage pipe.
// Optional build macro: SCANOUT_BORDER_EN paints a one-pixel frame around the visible area.
module lcd_scanout #(
  parameter int H_ACTIVE    = 480,
  parameter int H_FP        = 8,
  parameter int H_SYNC      = 4,
  parameter int H_BP        = 43,
  parameter int V_ACTIVE    = 272,
  parameter int V_FP        = 8,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 12,
  parameter int FB_W_LOG2   = 5,
  parameter int FB_H_LOG2   = 5,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_WIDTH  = 10
`ifdef SCANOUT_BORDER_EN
  ,
  parameter logic [15:0] BORDER_RGB565 = 16'hFFFF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [7:0]            ram_dout,
  output logic                  lcd_de,
  output logic                  lcd_hsync,
  output logic                  lcd_vsync,
  output logic [15:0]           lcd_rgb,
  output logic                  frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int FB_W_PIX = (1 << FB_W_LOG2) << SCALE_SHIFT;
  localparam int FB_H_PIX = (1 << FB_H_LOG2) << SCALE_SHIFT;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] FB_X_END = HW'(FB_W_PIX);
  localparam logic [VW-1:0] FB_Y_END = VW'(FB_H_PIX);

  // Per-pixel control flags that travel alongside the RAM read so everything lines up.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic fb;
`ifdef SCANOUT_BORDER_EN
    logic bd;
`endif
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{
    de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, fb: 1'b0
`ifdef SCANOUT_BORDER_EN
    , bd: 1'b0
`endif
  };

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  flags_t        s0, s1, s2;
  logic [15:0]   rgb_exp;
  logic [15:0]   pix_next;

  // Raster counters: pixel within line, line within frame, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage 0 decode of the current raster position into timing and region flags.
  always_comb begin
    s0    = FLAGS_IDLE;
    s0.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0.hs = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    s0.vs = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    s0.fs = (h_cnt == '0) && (v_cnt == '0);
    s0.fb = (h_cnt < FB_X_END) && (v_cnt < FB_Y_END);
`ifdef SCANOUT_BORDER_EN
    s0.bd = (h_cnt == '0) || (h_cnt == H_ACT - 1'b1) ||
            (v_cnt == '0) || (v_cnt == V_ACT - 1'b1);
`endif
  end

  // Stages 1-2: issue the RAM address and carry the flags across the read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      s1       <= FLAGS_IDLE;
      s2       <= FLAGS_IDLE;
    end else begin
      ram_addr <= s0.fb ? {v_cnt[SCALE_SHIFT +: FB_H_LOG2], h_cnt[SCALE_SHIFT +: FB_W_LOG2]}
                        : '0;
      s1       <= s0;
      s2       <= s1;
    end
  end

  // RGB332 to RGB565 by bit replication, then choose fb data, border or black.
  always_comb begin
    rgb_exp  = {ram_dout[7:5], ram_dout[7:6],
                ram_dout[4:2], ram_dout[4:2],
                ram_dout[1:0], ram_dout[1:0], ram_dout[1]};
    pix_next = '0;
    if (s2.de && s2.fb) pix_next = rgb_exp;
`ifdef SCANOUT_BORDER_EN
    if (s2.de && s2.bd) pix_next = BORDER_RGB565;
`endif
  end

  // Stage 3 output registers driving the panel pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_de      <= 1'b0;
      lcd_hsync   <= 1'b1;
      lcd_vsync   <= 1'b1;
      lcd_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      lcd_de      <= s2.de;
      lcd_hsync   <= s2.hs;
      lcd_vsync   <= s2.vs;
      lcd_rgb     <= pix_next;
      frame_start <= s2.fs;
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// tb_lcd_scanout: self-checking bench for lcd_scanout with a behavioural RAM and a
// position-based model of what the panel pins must show on every clock.
module tb_lcd_scanout;

  localparam int HT = 535;
  localparam int VT = 296;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_dout;
  logic        lcd_de;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic [15:0] lcd_rgb;
  logic        frame_start;

  logic [7:0]  mem [1024];

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  bit live     = 1'b0;

  lcd_scanout dut (
    .clk         (clk),
    .rst         (rst),
    .ram_addr    (ram_addr),
    .ram_dout    (ram_dout),
    .lcd_de      (lcd_de),
    .lcd_hsync   (lcd_hsync),
    .lcd_vsync   (lcd_vsync),
    .lcd_rgb     (lcd_rgb),
    .frame_start (frame_start)
  );

  // 10 ns pixel clock
  always #5 clk = ~clk;

  // Framebuffer RAM port B with one-cycle synchronous read
  always @(posedge clk) ram_dout <= mem[ram_addr];

  function automatic int posOf(int x, int y);
    return y * HT + x;
  endfunction

  function automatic logic [15:0] expandModel(logic [7:0] d);
    int r, g, b;
    r = int'(d) / 32;
    g = (int'(d) / 4) % 8;
    b = int'(d) % 4;
    return 16'((r * 4 + r / 2) * 2048 + (g * 8 + g) * 32 + (b * 8 + b * 2 + b / 2));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Compare every cycle against the raster model; pipeline delay is 3 for pins, 1 for address
  task automatic compareModel();
    int p, q, x, y, ea;
    logic ede, ehs, evs, efs;
    logic [15:0] ergb;
    p = k - 3;
    ede = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0; ergb = 16'h0;
    if (p >= 0) begin
      x = p % HT;
      y = (p / HT) % VT;
      ede = (x < 480) && (y < 272);
      ehs = !((x >= 488) && (x < 492));
      evs = !((y >= 280) && (y < 284));
      efs = (x == 0) && (y == 0);
      if (ede && x < 256 && y < 256) ergb = expandModel(mem[(y / 8) * 32 + x / 8]);
`ifdef SCANOUT_BORDER_EN
      if (ede && (x == 0 || x == 479 || y == 0 || y == 271)) ergb = 16'hFFFF;
`endif
    end
    q = k - 1;
    ea = 0;
    if (q >= 0) begin
      x = q % HT;
      y = (q / HT) % VT;
      if (x < 256 && y < 256) ea = (y / 8) * 32 + x / 8;
    end
    checkOutput("model_de", 32'(lcd_de), 32'(ede));
    checkOutput("model_hsync", 32'(lcd_hsync), 32'(ehs));
    checkOutput("model_vsync", 32'(lcd_vsync), 32'(evs));
    checkOutput("model_fs", 32'(frame_start), 32'(efs));
    checkOutput("model_rgb", 32'(lcd_rgb), 32'(ergb));
    checkOutput("model_addr", 32'(ram_addr), 32'(ea));
  endtask

  // Hand-computed expectations at fixed raster positions
  task automatic checkLiterals();
    if (k == 3) begin
      checkOutput("fs_after_release", 32'(frame_start), 32'd1);
      checkOutput("pix_0_0", 32'(lcd_rgb), 32'hF800);
      checkOutput("de_0_0", 32'(lcd_de), 32'd1);
    end
    if (k == posOf(7, 7) + 3)   checkOutput("pix_7_7", 32'(lcd_rgb), 32'hF800);
    if (k == posOf(5, 5) + 3)   checkOutput("pix_5_5", 32'(lcd_rgb), 32'hF800);
    if (k == posOf(8, 8) + 1)   checkOutput("addr_8_8", 32'(ram_addr), 32'd33);
    if (k == posOf(8, 8) + 3)   checkOutput("pix_8_8", 32'(lcd_rgb), 32'h07E0);
    if (k == posOf(15, 15) + 3) checkOutput("pix_15_15", 32'(lcd_rgb), 32'h07E0);
    if (k == posOf(256, 0) + 1) checkOutput("addr_256_0", 32'(ram_addr), 32'd0);
    if (k == posOf(256, 0) + 3) begin
      checkOutput("pix_256_0", 32'(lcd_rgb), 32'h0);
      checkOutput("de_256_0", 32'(lcd_de), 32'd1);
    end
    if (k == posOf(300, 20) + 3) begin
      checkOutput("pix_300_20", 32'(lcd_rgb), 32'h0);
      checkOutput("de_300_20", 32'(lcd_de), 32'd1);
    end
`ifdef SCANOUT_BORDER_EN
    if (k == posOf(0, 5) + 3)   checkOutput("border_0_5", 32'(lcd_rgb), 32'hFFFF);
    if (k == posOf(479, 5) + 3) checkOutput("border_479_5", 32'(lcd_rgb), 32'hFFFF);
    if (k == posOf(5, 0) + 3)   checkOutput("border_5_0", 32'(lcd_rgb), 32'hFFFF);
`else
    if (k == posOf(0, 5) + 3)   checkOutput("edge_0_5", 32'(lcd_rgb), 32'hF800);
    if (k == posOf(479, 5) + 3) checkOutput("edge_479_5", 32'(lcd_rgb), 32'h0);
    if (k == posOf(5, 0) + 3)   checkOutput("edge_5_0", 32'(lcd_rgb), 32'hF800);
`endif
  endtask

  // Monitor: sample #1 after each rising edge, track line timing and compare
  initial begin
    logic rstS;
    logic prevDe, prevHs;
    bit riseValid, hsValid;
    int cyc, riseCyc, deRun, hsRun;
    prevDe = 1'b0; prevHs = 1'b1;
    riseValid = 1'b0; hsValid = 1'b0;
    cyc = 0; riseCyc = 0; deRun = 0; hsRun = 0;
    forever begin
      @(posedge clk);
      rstS = rst;
      #1;
      cyc++;
      if (rstS) begin
        k = 0;
        live = 1'b1;
        riseValid = 1'b0;
        hsValid = 1'b0;
        checkOutput("rst_de", 32'(lcd_de), 32'd0);
        checkOutput("rst_hsync", 32'(lcd_hsync), 32'd1);
        checkOutput("rst_vsync", 32'(lcd_vsync), 32'd1);
        checkOutput("rst_rgb", 32'(lcd_rgb), 32'd0);
        checkOutput("rst_fs", 32'(frame_start), 32'd0);
        checkOutput("rst_addr", 32'(ram_addr), 32'd0);
      end else if (live) begin
        k++;
        compareModel();
        checkLiterals();
        if (lcd_de && !prevDe) begin
          riseValid = 1'b1;
          riseCyc = cyc;
          deRun = 0;
        end
        if (lcd_de) deRun++;
        if (!lcd_de && prevDe && riseValid) checkOutput("de_width", 32'(deRun), 32'd480);
        if (!lcd_hsync && prevHs) begin
          if (riseValid) checkOutput("hsync_offset", 32'(cyc - riseCyc), 32'd488);
          hsRun = 0;
          hsValid = 1'b1;
        end
        if (!lcd_hsync) hsRun++;
        if (lcd_hsync && !prevHs && hsValid) checkOutput("hsync_width", 32'(hsRun), 32'd4);
      end
      prevDe = lcd_de;
      prevHs = lcd_hsync;
    end
  end

  // Stimulus: preload RAM, reset, run to (200,100), pulse reset, run a few more lines
  task automatic applyStimulus();
    int target;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 5);
    mem[0]  = 8'hE0;
    mem[33] = 8'h1C;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    target = posOf(200, 100);
    for (int i = 0; i < 60000 && k != target; i++) @(negedge clk);
    checkOutput("reach_mid_line", 32'(k), 32'(target));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * HT + 10) @(negedge clk);
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
